// File: rtl/river_crossing_ctrl.sv
// river_crossing_ctrl
//   Game controller for the farmer/cabbage/goat/wolf river-crossing puzzle.
//   Tracks the bank of each item (0 = start bank, 1 = far bank). Accepts one
//   move per cycle, rejects illegal moves and declares the game won or lost.
//
// Ports
//   Clock       : system clock, rising edge
//   Resetn      : asynchronous active-low reset
//   move_valid  : perform move_sel at this edge (level sampled)
//   move_sel    : 00 farmer alone, 01 cabbage, 10 goat, 11 wolf
//   restart     : synchronous return to the start configuration
//   F/C/G/W     : registered bank of farmer/cabbage/goat/wolf
//   alarm       : combinational unsafe flag for the current F/C/G/W
//   playing/won/lost : one-hot game state
//   illegal     : one-cycle pulse after a rejected move
//   move_count  : accepted moves, saturating at 2^CNT_W-1
module river_crossing_ctrl #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             move_valid,
    input  logic [1:0]       move_sel,
    input  logic             restart,
    output logic             F,
    output logic             C,
    output logic             G,
    output logic             W,
    output logic             alarm,
    output logic             playing,
    output logic             won,
    output logic             lost,
    output logic             illegal,
    output logic [CNT_W-1:0] move_count
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WON  = 2'd1,
        LOST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pos_q, pos_d;      // {F, C, G, W}
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    logic [1:0]       item_idx;
    logic [3:0]       move_mask;
    logic             move_legal;

    // Goat left with wolf or cabbage while the farmer is on the other bank.
    function automatic logic unsafe_f(input logic [3:0] v);
        logic f, c, g, w;
        {f, c, g, w} = v;
        return (g != f) && ((g == w) || (g == c));
    endfunction

    always_comb begin
        // Bit index of the selected passenger within {F,C,G,W}.
        item_idx   = 2'd3 - move_sel;
        move_mask  = 4'b1000;
        move_legal = 1'b1;
        if (move_sel != 2'b00) begin
            move_mask[item_idx] = 1'b1;
            move_legal          = (pos_q[item_idx] == pos_q[3]);
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        if (restart) begin
            state_d = PLAY;
            pos_d   = '0;
            cnt_d   = '0;
        end else if (state_q == PLAY && move_valid) begin
            if (move_legal) begin
                pos_d = pos_q ^ move_mask;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (unsafe_f(pos_d)) begin
                    state_d = LOST;
                end else if (pos_d == 4'b1111) begin
                    state_d = WON;
                end
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= PLAY;
            pos_q     <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign {F, C, G, W} = pos_q;
    assign alarm        = unsafe_f(pos_q);
    assign playing      = (state_q == PLAY);
    assign won          = (state_q == WON);
    assign lost         = (state_q == LOST);
    assign illegal      = illegal_q;
    assign move_count   = cnt_q;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed bench for river_crossing_ctrl with hand-computed expectations.
module tb_river_crossing_ctrl;

    localparam int unsigned CNT_W = 5;

    logic             Clock;
    logic             Resetn;
    logic             move_valid;
    logic [1:0]       move_sel;
    logic             restart;
    logic             F, C, G, W;
    logic             alarm, playing, won, lost, illegal;
    logic [CNT_W-1:0] move_count;

    int unsigned n_cmp;
    int unsigned n_err;

    river_crossing_ctrl #(.CNT_W(CNT_W)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .move_valid (move_valid),
        .move_sel   (move_sel),
        .restart    (restart),
        .F          (F),
        .C          (C),
        .G          (G),
        .W          (W),
        .alarm      (alarm),
        .playing    (playing),
        .won        (won),
        .lost       (lost),
        .illegal    (illegal),
        .move_count (move_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed status: {state(won,lost,playing), F,C,G,W}
    function automatic logic [31:0] vec();
        return 32'({F, C, G, W});
    endfunction

    function automatic logic [31:0] st();
        return 32'({won, lost, playing});
    endfunction

    // Apply one move at the next rising edge, sample 1 time unit later.
    task automatic do_move(input logic [1:0] sel);
        move_valid = 1'b1;
        move_sel   = sel;
        @(posedge Clock);
        #1;
        move_valid = 1'b0;
        move_sel   = 2'b00;
    endtask

    task automatic idle_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        idle_cycle();
    endtask

    localparam logic [1:0] S_ALONE = 2'b00;
    localparam logic [1:0] S_CAB   = 2'b01;
    localparam logic [1:0] S_GOAT  = 2'b10;
    localparam logic [1:0] S_WOLF  = 2'b11;

    localparam logic [31:0] ST_PLAY = 32'b001;
    localparam logic [31:0] ST_LOST = 32'b010;
    localparam logic [31:0] ST_WON  = 32'b100;

    logic [1:0] win_sel [7];
    logic [3:0] win_vec [7];

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        Resetn     = 1'b1;
        move_valid = 1'b0;
        move_sel   = 2'b00;
        restart    = 1'b0;

        win_sel = '{S_GOAT, S_ALONE, S_CAB, S_GOAT, S_WOLF, S_ALONE, S_GOAT};
        win_vec = '{4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b1111};

        // Reset state
        #2;
        Resetn = 1'b0;
        #1;
        check("rst_vec", vec(), 32'h0);
        check("rst_state", st(), ST_PLAY);
        check("rst_cnt", 32'(move_count), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        idle_cycle();

        // Winning sequence
        for (int i = 0; i < 7; i++) begin
            do_move(win_sel[i]);
            check($sformatf("win_vec%0d", i), vec(), 32'(win_vec[i]));
            check($sformatf("win_alarm%0d", i), 32'(alarm), 32'd0);
            check($sformatf("win_cnt%0d", i), 32'(move_count), 32'(i + 1));
            check($sformatf("win_state%0d", i), st(), (i == 6) ? ST_WON : ST_PLAY);
        end
        // Terminal: a further move is ignored
        do_move(S_ALONE);
        check("won_frozen_vec", vec(), 32'hF);
        check("won_frozen_cnt", 32'(move_count), 32'd7);
        check("won_no_illegal", 32'(illegal), 32'd0);

        // Restart with simultaneous move: restart wins
        restart    = 1'b1;
        move_valid = 1'b1;
        move_sel   = S_GOAT;
        @(posedge Clock);
        #1;
        restart    = 1'b0;
        move_valid = 1'b0;
        check("restart_vec", vec(), 32'h0);
        check("restart_cnt", 32'(move_count), 32'd0);
        check("restart_state", st(), ST_PLAY);

        // Losing move: cabbage
        do_reset();
        do_move(S_CAB);
        check("lose_vec", vec(), 32'hC);
        check("lose_state", st(), ST_LOST);
        check("lose_alarm", 32'(alarm), 32'd1);
        do_move(S_GOAT);
        check("lost_frozen_vec", vec(), 32'hC);
        check("lost_frozen_cnt", 32'(move_count), 32'd1);
        check("lost_no_illegal", 32'(illegal), 32'd0);

        // Illegal move: wolf on the far side of the farmer
        do_reset();
        do_move(S_GOAT);
        do_move(S_WOLF);
        check("illegal_pulse", 32'(illegal), 32'd1);
        check("illegal_vec", vec(), 32'hA);
        check("illegal_cnt", 32'(move_count), 32'd1);
        check("illegal_state", st(), ST_PLAY);
        idle_cycle();
        check("illegal_clear", 32'(illegal), 32'd0);
        check("idle_hold_vec", vec(), 32'hA);

        // Illegal from a different bank mismatch: cabbage while farmer on far bank
        do_move(S_CAB);
        check("illegal_cab", 32'(illegal), 32'd1);
        check("illegal_cab_vec", vec(), 32'hA);

        // Saturation: 40 goat moves
        do_reset();
        for (int i = 0; i < 40; i++) begin
            do_move(S_GOAT);
            if (i == 38) begin
                check("sat_vec_odd", vec(), 32'hA);
                check("sat_cnt_39", 32'(move_count), 32'd31);
            end
        end
        check("sat_vec", vec(), 32'h0);
        check("sat_cnt", 32'(move_count), 32'd31);
        check("sat_state", st(), ST_PLAY);

        // Asynchronous reset mid-game at 0100
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_move(win_sel[i]);
        end
        check("pre_areset_vec", vec(), 32'h4);
        #2;
        Resetn = 1'b0;
        #1;
        check("areset_vec", vec(), 32'h0);
        check("areset_cnt", 32'(move_count), 32'd0);
        check("areset_state", st(), ST_PLAY);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        idle_cycle();
        check("post_areset_vec", vec(), 32'h0);
        check("post_areset_illegal", 32'(illegal), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
